mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one single-port memory bus between the instruction-fetch port and the MEM-stage data port. Each access uses a req/ack handshake with variable latency.
- Owns sequencing for both ports: grant, bus cycle, wait for ack or timeout, one-cycle completion.
- Produces per-port stall requests for the pipeline control block.
- Supports discarding an in-flight fetch when an exception or mret flushes the pipeline.

Parameters:
ADDR_W, 32, address width of both ports and of the bus
DATA_W, 32, data width
TIMEOUT, 255, cycles without bus_ack_i before the access is aborted; counter width is 8 bits

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
flush_i  in  1  pipeline flush (exception or mret); affects the fetch port only
if_ce_i  in  1  fetch request
if_addr_i  in  ADDR_W  fetch address
if_data_o  out  DATA_W  fetched instruction; valid in IF-done cycle
if_stall_o  out  1  fetch stall request
d_ce_i  in  1  data request, driven from MEM-stage chip enable
d_we_i  in  1  data write enable, already exception-masked upstream
d_addr_i  in  ADDR_W  data address
d_sel_i  in  4  byte lanes; sel[3] is addr[1:0]=00 (big-endian lane order)
d_data_i  in  DATA_W  store data
d_data_o  out  DATA_W  load data; valid in D-done cycle
d_stall_o  out  1  data stall request
bus_cyc_o  out  1  bus cycle active
bus_we_o  out  1  bus write
bus_addr_o  out  ADDR_W  bus address
bus_sel_o  out  4  bus byte lanes
bus_data_o  out  DATA_W  bus write data
bus_data_i  in  DATA_W  bus read data
bus_ack_i  in  1  bus completion, one cycle
bus_err_o  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state IDLE, last_grant=IF, discard=0, timeout counter 0.
  - All bus_* outputs 0, bus_err_o 0.
  - if_data_o and d_data_o 0.
  - Reset mid-transaction abandons it: bus_cyc_o is 0 the next cycle and any late ack is ignored.
- States:
  - IDLE
  - IF_BUSY, D_BUSY: bus cycle in flight
  - IF_DONE, D_DONE: one-cycle completion
- Grant from IDLE:
  - Only d_ce_i: go to D_BUSY.
  - Only if_ce_i: go to IF_BUSY.
  - Both: D wins unless last_grant=D, in which case IF wins (alternation, no starvation).
  - last_grant updates on every grant.
- On grant, all bus outputs are registered:
  - bus_cyc_o=1.
  - D: bus_we_o=d_we_i, bus_addr_o=d_addr_i, bus_sel_o=d_sel_i, bus_data_o=d_data_i.
  - IF: we=0, sel=4'b1111, bus_data_o=0, bus_addr_o=if_addr_i.
  - Outputs stay constant until the bus cycle ends.
- Leaving BUSY on bus_ack_i=1:
  - bus_cyc_o=0 next cycle; go to the matching DONE.
  - D read: latch bus_data_i into d_data_o. IF: latch into if_data_o.
  - D write: d_data_o holds its previous value.
- DONE lasts one cycle, then IDLE. Minimum 3 cycles per access (grant, ack, done).
- Stall rules (combinational):
  - d_stall_o = d_ce_i & (state != D_DONE).
  - if_stall_o = if_ce_i & (state != IF_DONE) & ~flush_i.
- Timeout:
  - The counter increments every BUSY cycle without ack and clears on leaving BUSY.
  - When the counter reaches TIMEOUT: bus_cyc_o drops, bus_err_o pulses for 1 cycle, the target data output is set to 0, and the state goes to DONE.
- Flush:
  - flush_i in IF_BUSY sets discard. The bus cycle still completes (no abort on the bus).
  - On ack with discard=1: go to IDLE, not IF_DONE; if_data_o is unchanged; discard clears.
  - flush_i in IF_DONE suppresses nothing further.
  - flush_i in D_BUSY has no effect: an accepted store always completes.
- Simultaneous ack and flush in IF_BUSY: discard applies; go to IDLE.
- bus_ack_i outside a BUSY state is ignored.

Test Plan:
- Load only:
  - Stimulus: d_ce=1, we=0, addr=0x100, sel=4'b1111; ack two cycles after bus_cyc_o rises with bus_data_i=0xDEADBEEF.
  - Required: d_stall_o=1 for 3 cycles, then 0 for one cycle with d_data_o=0xDEADBEEF; bus_we_o=0 throughout.
- Contention:
  - Stimulus: if_ce and d_ce high together from reset, 1-cycle ack.
  - Required: grant order D, IF, D, IF; if_stall_o high until IF_DONE.
- Byte store:
  - Stimulus: d_we=1, addr=0x203, sel=4'b0001, data=0x5A5A5A5A.
  - Required: bus outputs exactly those values; d_data_o unchanged.
- Fetch flush:
  - Stimulus: IF_BUSY to addr 0x80; flush_i pulse; ack with 0x13.
  - Required: no IF_DONE, if_data_o keeps its old value, next grant in the following cycle.
- Timeout:
  - Stimulus: D read with no ack.
  - Required: after 255 busy cycles bus_cyc_o=0, bus_err_o single pulse, d_data_o=0, d_stall_o low for one cycle.
- Reset mid-cycle:
  - Stimulus: rst=1 during D_BUSY, then a late ack.
  - Required: all outputs 0 next cycle; the ack causes no state change.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between the instruction-fetch port and the data port.
// Each access takes a grant cycle, one or more bus cycles until ack or timeout, and one done cycle.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              if_ce_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_stall_o,
  input  logic              d_ce_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [3:0]        d_sel_i,
  input  logic [DATA_W-1:0] d_data_i,
  output logic [DATA_W-1:0] d_data_o,
  output logic              d_stall_o,
  output logic              bus_cyc_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [DATA_W-1:0] bus_data_o,
  input  logic [DATA_W-1:0] bus_data_i,
  input  logic              bus_ack_i,
  output logic              bus_err_o
);

  typedef enum logic [2:0] {IDLE, IF_BUSY, D_BUSY, IF_DONE, D_DONE} state_t;

  // Counter tops out one short of TIMEOUT so the abort lands on the TIMEOUT-th busy cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t              state, state_nx;
  logic                last_d, last_d_nx;
  logic                discard, discard_nx;
  logic [7:0]          tmo_cnt, tmo_cnt_nx;
  logic                cyc_nx, we_nx, err_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [3:0]          sel_nx;
  logic [DATA_W-1:0]   wdata_nx, if_data_nx, d_data_nx;
  logic                grant_d, drop_fetch, tmo_hit;

  // Data wins a tie unless it also won the previous grant.
  assign grant_d    = d_ce_i & (~if_ce_i | ~last_d);
  assign drop_fetch = discard | flush_i;
  assign tmo_hit    = (tmo_cnt == TMO_LAST);

  assign d_stall_o  = d_ce_i & (state != D_DONE);
  assign if_stall_o = if_ce_i & (state != IF_DONE) & ~flush_i;

  always_comb begin
    state_nx   = state;
    last_d_nx  = last_d;
    discard_nx = discard;
    tmo_cnt_nx = tmo_cnt;
    cyc_nx     = bus_cyc_o;
    we_nx      = bus_we_o;
    addr_nx    = bus_addr_o;
    sel_nx     = bus_sel_o;
    wdata_nx   = bus_data_o;
    if_data_nx = if_data_o;
    d_data_nx  = d_data_o;
    err_nx     = 1'b0;

    case (state)
      IDLE: begin
        tmo_cnt_nx = '0;
        discard_nx = 1'b0;
        if (d_ce_i | if_ce_i) begin
          cyc_nx    = 1'b1;
          last_d_nx = grant_d;
          if (grant_d) begin
            state_nx = D_BUSY;
            we_nx    = d_we_i;
            addr_nx  = d_addr_i;
            sel_nx   = d_sel_i;
            wdata_nx = d_data_i;
          end else begin
            state_nx = IF_BUSY;
            we_nx    = 1'b0;
            addr_nx  = if_addr_i;
            sel_nx   = 4'b1111;
            wdata_nx = '0;
          end
        end
      end

      IF_BUSY: begin
        if (bus_ack_i || tmo_hit) begin
          tmo_cnt_nx = '0;
          discard_nx = 1'b0;
          err_nx     = ~bus_ack_i;
          // A flushed fetch still finishes on the bus but never reaches IF_DONE.
          if (drop_fetch) begin
            state_nx = IDLE;
          end else begin
            state_nx   = IF_DONE;
            if_data_nx = bus_ack_i ? bus_data_i : '0;
          end
        end else begin
          tmo_cnt_nx = tmo_cnt + 8'd1;
          if (flush_i) discard_nx = 1'b1;
        end
      end

      D_BUSY: begin
        if (bus_ack_i) begin
          tmo_cnt_nx = '0;
          state_nx   = D_DONE;
          if (!bus_we_o) d_data_nx = bus_data_i;
        end else if (tmo_hit) begin
          tmo_cnt_nx = '0;
          state_nx   = D_DONE;
          err_nx     = 1'b1;
          d_data_nx  = '0;
        end else begin
          tmo_cnt_nx = tmo_cnt + 8'd1;
        end
      end

      default: state_nx = IDLE;
    endcase

    // Bus is parked at zero whenever no cycle is in flight.
    if ((state == IF_BUSY || state == D_BUSY) && (bus_ack_i || tmo_hit)) begin
      cyc_nx   = 1'b0;
      we_nx    = 1'b0;
      addr_nx  = '0;
      sel_nx   = '0;
      wdata_nx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_d     <= 1'b0;
      discard    <= 1'b0;
      tmo_cnt    <= '0;
      bus_cyc_o  <= 1'b0;
      bus_we_o   <= 1'b0;
      bus_addr_o <= '0;
      bus_sel_o  <= '0;
      bus_data_o <= '0;
      bus_err_o  <= 1'b0;
      if_data_o  <= '0;
      d_data_o   <= '0;
    end else begin
      state      <= state_nx;
      last_d     <= last_d_nx;
      discard    <= discard_nx;
      tmo_cnt    <= tmo_cnt_nx;
      bus_cyc_o  <= cyc_nx;
      bus_we_o   <= we_nx;
      bus_addr_o <= addr_nx;
      bus_sel_o  <= sel_nx;
      bus_data_o <= wdata_nx;
      bus_err_o  <= err_nx;
      if_data_o  <= if_data_nx;
      d_data_o   <= d_data_nx;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios plus a randomized transaction stream checked against a
// transaction-level model of grant order, bus fields and returned data.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst, flush, if_ce, d_ce, d_we, bus_ack;
  logic [31:0] if_addr, d_addr, d_wdata, bus_rdata;
  logic [3:0]  d_sel;
  logic [31:0] if_data, d_data, bus_addr, bus_data;
  logic [3:0]  bus_sel;
  logic        if_stall, d_stall, bus_cyc, bus_we, bus_err;

  int passes = 0, checks = 0;
  logic [31:0] exp_if = '0, exp_d = '0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .if_ce_i(if_ce), .if_addr_i(if_addr), .if_data_o(if_data), .if_stall_o(if_stall),
    .d_ce_i(d_ce), .d_we_i(d_we), .d_addr_i(d_addr), .d_sel_i(d_sel), .d_data_i(d_wdata),
    .d_data_o(d_data), .d_stall_o(d_stall),
    .bus_cyc_o(bus_cyc), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_sel_o(bus_sel),
    .bus_data_o(bus_data), .bus_data_i(bus_rdata), .bus_ack_i(bus_ack), .bus_err_o(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick; @(negedge clk); endtask

  task automatic idle_inputs;
    if_ce = 0; d_ce = 0; d_we = 0; flush = 0; bus_ack = 0;
    if_addr = '0; d_addr = '0; d_sel = '0; d_wdata = '0; bus_rdata = '0;
  endtask

  task automatic test_reset;
    rst = 1; idle_inputs(); tick(); tick(); rst = 0;
    checks++; if (bus_cyc !== 1'b0) $display("FAIL reset_cyc got %b exp 0", bus_cyc); else passes++;
    checks++; if (bus_we !== 1'b0) $display("FAIL reset_we got %b exp 0", bus_we); else passes++;
    checks++; if (bus_addr !== 32'h0) $display("FAIL reset_addr got %h exp 0", bus_addr); else passes++;
    checks++; if (bus_sel !== 4'h0) $display("FAIL reset_sel got %h exp 0", bus_sel); else passes++;
    checks++; if (bus_data !== 32'h0) $display("FAIL reset_wdata got %h exp 0", bus_data); else passes++;
    checks++; if (bus_err !== 1'b0) $display("FAIL reset_err got %b exp 0", bus_err); else passes++;
    checks++; if (if_data !== 32'h0) $display("FAIL reset_if_data got %h exp 0", if_data); else passes++;
    checks++; if (d_data !== 32'h0) $display("FAIL reset_d_data got %h exp 0", d_data); else passes++;
    exp_if = '0; exp_d = '0;
  endtask

  task automatic test_load;
    d_ce = 1; d_we = 0; d_addr = 32'h100; d_sel = 4'hf; d_wdata = $urandom; #1;
    checks++; if (d_stall !== 1'b1) $display("FAIL load_stall0 got %b exp 1", d_stall); else passes++;
    tick();
    checks++; if (bus_cyc !== 1'b1) $display("FAIL load_cyc got %b exp 1", bus_cyc); else passes++;
    checks++; if (bus_addr !== 32'h100) $display("FAIL load_addr got %h exp 100", bus_addr); else passes++;
    checks++; if (bus_sel !== 4'hf) $display("FAIL load_sel got %h exp f", bus_sel); else passes++;
    checks++; if (bus_we !== 1'b0) $display("FAIL load_we1 got %b exp 0", bus_we); else passes++;
    checks++; if (d_stall !== 1'b1) $display("FAIL load_stall1 got %b exp 1", d_stall); else passes++;
    tick();
    checks++; if (bus_we !== 1'b0) $display("FAIL load_we2 got %b exp 0", bus_we); else passes++;
    checks++; if (d_stall !== 1'b1) $display("FAIL load_stall2 got %b exp 1", d_stall); else passes++;
    bus_ack = 1; bus_rdata = 32'hDEADBEEF;
    tick(); bus_ack = 0;
    exp_d = 32'hDEADBEEF;
    checks++; if (d_stall !== 1'b0) $display("FAIL load_done_stall got %b exp 0", d_stall); else passes++;
    checks++; if (d_data !== exp_d) $display("FAIL load_data got %h exp %h", d_data, exp_d); else passes++;
    checks++; if (bus_cyc !== 1'b0) $display("FAIL load_done_cyc got %b exp 0", bus_cyc); else passes++;
    d_ce = 0; tick();
  endtask

  task automatic test_byte_store;
    d_ce = 1; d_we = 1; d_addr = 32'h203; d_sel = 4'b0001; d_wdata = 32'h5A5A5A5A;
    tick();
    checks++; if (bus_we !== 1'b1) $display("FAIL store_we got %b exp 1", bus_we); else passes++;
    checks++; if (bus_addr !== 32'h203) $display("FAIL store_addr got %h exp 203", bus_addr); else passes++;
    checks++; if (bus_sel !== 4'b0001) $display("FAIL store_sel got %b exp 0001", bus_sel); else passes++;
    checks++; if (bus_data !== 32'h5A5A5A5A) $display("FAIL store_wdata got %h exp 5a5a5a5a", bus_data); else passes++;
    bus_ack = 1; bus_rdata = 32'h12345678;
    tick(); bus_ack = 0;
    checks++; if (d_data !== exp_d) $display("FAIL store_d_data got %h exp %h", d_data, exp_d); else passes++;
    checks++; if (d_stall !== 1'b0) $display("FAIL store_done_stall got %b exp 0", d_stall); else passes++;
    d_ce = 0; d_we = 0; tick();
  endtask

  task automatic test_timeout;
    int n = 0;
    bit err_early = 0;
    d_ce = 1; d_we = 0; d_addr = 32'h300; d_sel = 4'hf;
    tick();
    while (bus_cyc === 1'b1 && n < 300) begin
      if (bus_err !== 1'b0) err_early = 1;
      n++; tick();
    end
    checks++; if (n != 255) $display("FAIL tmo_busy_cycles got %0d exp 255", n); else passes++;
    checks++; if (err_early) $display("FAIL tmo_err_early got 1 exp 0"); else passes++;
    checks++; if (bus_err !== 1'b1) $display("FAIL tmo_err got %b exp 1", bus_err); else passes++;
    checks++; if (d_data !== 32'h0) $display("FAIL tmo_d_data got %h exp 0", d_data); else passes++;
    checks++; if (d_stall !== 1'b0) $display("FAIL tmo_stall got %b exp 0", d_stall); else passes++;
    exp_d = '0;
    d_ce = 0; tick();
    checks++; if (bus_err !== 1'b0) $display("FAIL tmo_err_pulse got %b exp 0", bus_err); else passes++;
  endtask

  task automatic test_contention;
    rst = 1; idle_inputs(); tick(); rst = 0; exp_if = '0; exp_d = '0;
    if_ce = 1; d_ce = 1; if_addr = 32'h400; d_addr = 32'h500; d_sel = 4'hf;
    for (int g = 0; g < 4; g++) begin
      bit isd = (g % 2 == 0);
      tick();
      checks++; if (bus_addr !== (isd ? 32'h500 : 32'h400)) $display("FAIL cont_order%0d got %h exp %h", g, bus_addr, isd ? 32'h500 : 32'h400); else passes++;
      checks++; if (if_stall !== 1'b1) $display("FAIL cont_if_stall_busy%0d got %b exp 1", g, if_stall); else passes++;
      bus_ack = 1; bus_rdata = $urandom;
      if (isd) exp_d = bus_rdata; else exp_if = bus_rdata;
      tick(); bus_ack = 0;
      checks++; if (if_stall !== !isd ? 1'b0 : 1'b1) $display("FAIL cont_if_stall_done%0d got %b exp %b", g, if_stall, isd); else passes++;
      checks++; if (d_stall !== (isd ? 1'b0 : 1'b1)) $display("FAIL cont_d_stall_done%0d got %b exp %b", g, d_stall, !isd); else passes++;
      tick();
      checks++; if (if_stall !== 1'b1) $display("FAIL cont_if_stall_idle%0d got %b exp 1", g, if_stall); else passes++;
    end
    checks++; if (if_data !== exp_if) $display("FAIL cont_if_data got %h exp %h", if_data, exp_if); else passes++;
    checks++; if (d_data !== exp_d) $display("FAIL cont_d_data got %h exp %h", d_data, exp_d); else passes++;
    if_ce = 0; d_ce = 0;
    tick();
  endtask

  task automatic test_fetch_flush;
    if_ce = 1; if_addr = 32'h80;
    tick();
    checks++; if (bus_addr !== 32'h80) $display("FAIL flush_addr got %h exp 80", bus_addr); else passes++;
    checks++; if (bus_sel !== 4'hf || bus_we !== 1'b0 || bus_data !== 32'h0) $display("FAIL flush_fetch_fields got sel=%h we=%b data=%h exp f/0/0", bus_sel, bus_we, bus_data); else passes++;
    flush = 1; tick(); flush = 0;
    bus_ack = 1; bus_rdata = 32'h13; tick(); bus_ack = 0;
    checks++; if (bus_cyc !== 1'b0) $display("FAIL flush_cyc_end got %b exp 0", bus_cyc); else passes++;
    checks++; if (if_data !== exp_if) $display("FAIL flush_if_data got %h exp %h", if_data, exp_if); else passes++;
    checks++; if (if_stall !== 1'b1) $display("FAIL flush_no_done got %b exp 1", if_stall); else passes++;
    tick();
    checks++; if (bus_cyc !== 1'b1 || bus_addr !== 32'h80) $display("FAIL flush_regrant got cyc=%b addr=%h exp 1/80", bus_cyc, bus_addr); else passes++;
    flush = 1; bus_ack = 1; bus_rdata = 32'h77; tick();
    flush = 0; bus_ack = 0; #1;
    checks++; if (if_stall !== 1'b1) $display("FAIL flush_ack_same_cycle got %b exp 1", if_stall); else passes++;
    checks++; if (if_data !== exp_if) $display("FAIL flush_ack_if_data got %h exp %h", if_data, exp_if); else passes++;
    if_ce = 0; tick();
  endtask

  task automatic test_reset_mid;
    d_ce = 1; d_we = 0; d_addr = 32'h600; d_sel = 4'hf;
    tick();
    checks++; if (bus_cyc !== 1'b1) $display("FAIL rmid_busy got %b exp 1", bus_cyc); else passes++;
    rst = 1; tick();
    checks++; if ({bus_cyc, bus_we, bus_err, bus_sel} !== 7'h0 || bus_addr !== 32'h0 || bus_data !== 32'h0) $display("FAIL rmid_bus got cyc=%b addr=%h sel=%h exp zero", bus_cyc, bus_addr, bus_sel); else passes++;
    checks++; if (if_data !== 32'h0 || d_data !== 32'h0) $display("FAIL rmid_data got if=%h d=%h exp 0/0", if_data, d_data); else passes++;
    rst = 0; d_ce = 0; bus_ack = 1; bus_rdata = 32'hCAFEF00D; tick(); bus_ack = 0;
    d_ce = 1; #1;
    checks++; if (d_stall !== 1'b1) $display("FAIL rmid_late_ack_stall got %b exp 1", d_stall); else passes++;
    checks++; if (bus_cyc !== 1'b0 || d_data !== 32'h0) $display("FAIL rmid_late_ack got cyc=%b d=%h exp 0/0", bus_cyc, d_data); else passes++;
    d_ce = 0; tick();
    exp_if = '0; exp_d = '0;
  endtask

  task automatic test_random;
    bit last_d = 0;
    rst = 1; idle_inputs(); tick(); rst = 0; exp_if = '0; exp_d = '0;
    for (int t = 0; t < 40; t++) begin
      int pat = $urandom_range(1, 3);
      int lat = $urandom_range(0, 4);
      bit ifc = pat[0], dc = pat[1], gd;
      logic [31:0] e_addr, e_wdata, rd = '0;
      logic [3:0] e_sel;
      bit e_we;
      if_ce = ifc; d_ce = dc; if_addr = $urandom; d_addr = $urandom;
      d_we = $urandom_range(0, 1); d_sel = $urandom; d_wdata = $urandom; #1;
      checks++; if (d_stall !== dc || if_stall !== ifc) $display("FAIL rnd%0d_req_stall got d=%b if=%b exp %b/%b", t, d_stall, if_stall, dc, ifc); else passes++;
      gd = dc && (!ifc || !last_d);
      e_we = gd ? d_we : 1'b0; e_addr = gd ? d_addr : if_addr;
      e_sel = gd ? d_sel : 4'hf; e_wdata = gd ? d_wdata : 32'h0;
      tick();
      checks++; if (bus_cyc !== 1'b1 || bus_we !== e_we || bus_addr !== e_addr || bus_sel !== e_sel || bus_data !== e_wdata)
        $display("FAIL rnd%0d_grant got cyc=%b we=%b a=%h s=%h d=%h exp 1/%b/%h/%h/%h", t, bus_cyc, bus_we, bus_addr, bus_sel, bus_data, e_we, e_addr, e_sel, e_wdata);
      else passes++;
      for (int i = 0; i <= lat; i++) begin
        if (i > 0) begin
          checks++; if (bus_cyc !== 1'b1) $display("FAIL rnd%0d_hold%0d got %b exp 1", t, i, bus_cyc); else passes++;
        end
        bus_ack = (i == lat); rd = $urandom; bus_rdata = rd;
        flush = gd ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
      end
      bus_ack = 0; flush = 0; #1;
      if (gd) begin if (!e_we) exp_d = rd; end else exp_if = rd;
      last_d = gd;
      checks++; if (bus_cyc !== 1'b0 || bus_err !== 1'b0) $display("FAIL rnd%0d_end got cyc=%b err=%b exp 0/0", t, bus_cyc, bus_err); else passes++;
      checks++; if (d_data !== exp_d || if_data !== exp_if) $display("FAIL rnd%0d_data got d=%h if=%h exp %h/%h", t, d_data, if_data, exp_d, exp_if); else passes++;
      checks++; if (d_stall !== (dc && !gd) || if_stall !== (ifc && gd)) $display("FAIL rnd%0d_done_stall got d=%b if=%b exp %b/%b", t, d_stall, if_stall, dc && !gd, ifc && gd); else passes++;
      if_ce = 0; d_ce = 0; tick();
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_byte_store();
    test_timeout();
    test_contention();
    test_fetch_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
